ps2_keypad_decoder: RTL and testbench
=====================================

Name: ps2_keypad_decoder

Overview:
- Receives PS/2 keyboard frames (scan-code set 2) on the ps2_clk/ps2_data lines.
- Decodes make codes of game keys into single-cycle one-hot command pulses on `operation`.
- Sits between the board PS/2 pins and the cursor/elimination logic of the game top level, all on the 50 MHz system clock.

Parameters:
- SYNC_STAGES, 2: flip-flop stages synchronizing ps2_clk and ps2_data into clk domain (min 2).
- TIMEOUT_CYCLES, 50000: clk cycles without a ps2_clk falling edge before a partial frame is discarded (1 ms at 50 MHz).

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: asynchronous, active-high reset.
- ps2_clk, input, 1: raw PS/2 clock from keyboard; asynchronous; idle high.
- ps2_data, input, 1: raw PS/2 data from keyboard; asynchronous; idle high.
- operation, output, 5: one-hot command pulse.
  - bit0 up, bit1 down, bit2 left, bit3 right, bit4 select/eliminate.
  - 5'b00000 = no command.

Behaviour:
- Reset (async, rst=1): operation=0; bit counter=0; shift register=0; break flag=0; extended flag=0; timeout counter=0; synchronizers preset to 1 (idle).
- Synchronization: ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge is detected when the previous synchronized ps2_clk=1 and the current synchronized ps2_clk=0.
- Frame capture: on each detected falling edge, sample synchronized ps2_data. The frame is 11 bits, in this order:
  - start (0)
  - 8 data bits, LSB first
  - parity (odd)
  - stop (1)
- Bit counter runs 0..10 and wraps to 0 after bit 10.
- Start-bit check: if bit 0 samples 1, the counter stays at 0 (resync, no frame).
- Frame completion: at the 11th edge, if stop=1, assert an internal byte_valid for exactly one clk cycle (cycle N) with the data byte. Stop=0 discards the frame.
- Timeout: the counter increments each clk while the bit counter is non-zero and resets on every falling edge. On reaching TIMEOUT_CYCLES, bit counter is cleared and the partial frame is dropped.
- Byte decoder (acts on byte_valid):
  - 0xE0: set extended flag; no output.
  - 0xF0: set break flag; no output.
  - Any other byte, break flag=1: no output; clear both flags.
  - Any other byte, break flag=0: look up the code, pulse operation if mapped, clear both flags.
- Key map, non-extended:
  - 0x1D (W) up
  - 0x1B (S) down
  - 0x1C (A) left
  - 0x23 (D) right
  - 0x29 (Space) select
  - 0x5A (Enter) select
- Key map, extended (E0-prefixed):
  - 0x75 up
  - 0x72 down
  - 0x6B left
  - 0x74 right
  - E0 5A (keypad Enter) select
- Unmapped codes produce no pulse.
- Extended flag gates the lookup: with it set, only the extended map applies (e.g. E0 1D gives no pulse).
- Output timing: operation is registered and equals the mapped one-hot value in cycle N+1 only; 0 in all other cycles. Never more than one bit set.
- Typematic repeats (repeated make codes while a key is held) each produce a separate pulse.
- Latency: the pulse appears SYNC_STAGES+2 clk cycles after the raw ps2_clk falling edge of the stop bit.
- rst asserted mid-frame aborts the frame. After release, capture restarts at the next start bit.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: the XOR of the 8 data bits and the parity bit must be 1. Otherwise the frame is dropped (no byte_valid, flags unchanged).
- Undefined: the parity bit is sampled but ignored; frames with correct start/stop are accepted.

Test Plan:
- Reset: assert rst with ps2 lines idle high → operation=5'b00000; stays 0 for 1000 cycles after release.
- Send frame 0x1D (W) at ~12 kHz PS/2 clock → operation=5'b00001 for exactly one cycle, SYNC_STAGES+2 cycles after the stop-bit edge. Then send F0 1D → no further pulse.
- Send E0 74, then E0 F0 74 → one pulse operation=5'b01000; the break sequence produces none. Send E0 1D → no pulse.
- Send 0x29 then 0x5A → two pulses, each 5'b10000. Send 0x15 (Q) → no pulse; next 0x1B gives 5'b00010.
- Send 5 bits of a frame, idle 60000 cycles, then a full 0x1C frame → only 5'b00100 pulse, no garbage.
- With PS2_PARITY_CHECK_EN: send 0x23 with wrong parity → no pulse; correct parity → 5'b01000. Without the macro, the wrong-parity frame → 5'b01000.

Source files
------------

// File: rtl/ps2_keypad_decoder_if.sv
// ps2_keypad_decoder_if: PS/2 pin pair plus one-hot command output.
// The master side is the keyboard/board model; the slave side is the decoder.
interface ps2_keypad_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [4:0] operation;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  operation
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output operation
    );
endinterface

// File: rtl/ps2_keypad_decoder.sv
// ps2_keypad_decoder: PS/2 set-2 receiver decoding game keys to one-hot pulses.
// Define PS2_PARITY_CHECK_EN to drop frames failing the odd-parity check.
module ps2_keypad_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic                 clk,
    input logic                 rst,
    ps2_keypad_decoder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   sdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall  = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign sdata = data_sync[SYNC_STAGES-1];

    rx_state_t     state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_q, valid_d;
    logic [7:0]    byte_q, byte_d;
    logic          par_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic par_q, par_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_ok = ^{shift_q, par_q};
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tmo_q     <= '0;
            valid_q   <= 1'b0;
            byte_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
            valid_q   <= valid_d;
            byte_q    <= byte_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        valid_d   = 1'b0;
        byte_d    = byte_q;
`ifdef PS2_PARITY_CHECK_EN
        par_d     = par_q;
`endif
        if (fall) begin
            tmo_d = '0;
            unique case (state_q)
                IDLE: begin
                    // A high start bit is line noise; stay put and resync
                    if (!sdata) begin
                        state_d   = DATA;
                        bit_cnt_d = 4'd1;
                    end
                end
                DATA: begin
                    shift_d   = {sdata, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd8) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d     = sdata;
`endif
                    bit_cnt_d = 4'd10;
                    state_d   = STOP;
                end
                STOP: begin
                    if (sdata && par_ok) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            endcase
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_d     = '0;
                bit_cnt_d = '0;
                state_d   = IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    function automatic logic [4:0] lookup(input logic ext, input logic [7:0] code);
        logic [4:0] op;
        op = 5'b00000;
        if (ext) begin
            case (code)
                8'h75:   op = 5'b00001;
                8'h72:   op = 5'b00010;
                8'h6B:   op = 5'b00100;
                8'h74:   op = 5'b01000;
                8'h5A:   op = 5'b10000;
                default: op = 5'b00000;
            endcase
        end else begin
            case (code)
                8'h1D:   op = 5'b00001;
                8'h1B:   op = 5'b00010;
                8'h1C:   op = 5'b00100;
                8'h23:   op = 5'b01000;
                8'h29:   op = 5'b10000;
                8'h5A:   op = 5'b10000;
                default: op = 5'b00000;
            endcase
        end
        return op;
    endfunction

    logic       ext_q;
    logic       brk_q;
    logic [4:0] op_q;
    logic       is_e0;
    logic       is_f0;
    logic       is_key;

    assign is_e0  = (byte_q == 8'hE0);
    assign is_f0  = (byte_q == 8'hF0);
    assign is_key = !is_e0 && !is_f0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            op_q  <= '0;
        end else begin
            op_q <= '0;
            if (valid_q) begin
                unique case (1'b1)
                    is_e0: ext_q <= 1'b1;
                    is_f0: brk_q <= 1'b1;
                    is_key && brk_q: begin
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                    end
                    is_key && !brk_q: begin
                        op_q  <= lookup(ext_q, byte_q);
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.operation = op_q;
endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// tb_ps2_keypad_decoder: directed and random PS/2 frames against a key-map model.
// Pulse value, width, latency and one-hotness are compared per frame.
module tb_ps2_keypad_decoder;
    localparam int S  = 2;
    localparam int TO = 2000;
    localparam int H  = 20;

    logic clk;
    logic rst;
    int   cyc;

    ps2_keypad_decoder_if bus ();

    ps2_keypad_decoder #(
        .SYNC_STAGES   (S),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks;
    int errors;
    int pulses;
    int last_op;
    int pulse_cyc;
    int stop_cyc;
    int multi_hot;

    always @(negedge clk) begin
        if (bus.operation != 5'b0) begin
            if (pulses == 0) pulse_cyc = cyc;
            pulses  = pulses + 1;
            last_op = int'(bus.operation);
            if ($countones(bus.operation) > 1) multi_hot = multi_hot + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [4:0] plain_map [logic [7:0]];
    logic [4:0] ext_map   [logic [7:0]];
    bit         m_ext;
    bit         m_brk;

    function automatic int model_byte(input logic [7:0] b);
        int exp;
        exp = 0;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (!m_brk) begin
                if (m_ext) exp = ext_map.exists(b) ? int'(ext_map[b]) : 0;
                else exp = plain_map.exists(b) ? int'(plain_map[b]) : 0;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        return exp;
    endfunction

    task automatic send_bits(input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input int nbits);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = b;
        f[9]    = (~^b) ^ bad_par;
        f[10]   = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.ps2_data = f[i];
            repeat (H) @(negedge clk);
            bus.ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (H) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        @(negedge clk);
        bus.ps2_data = 1'b1;
    endtask

    task automatic clear_mon();
        pulses    = 0;
        last_op   = 0;
        pulse_cyc = -1;
    endtask

    task automatic frame(input string tag, input logic [7:0] b,
                         input bit bad_par, input bit bad_stop);
        int  exp;
        bit  ok;
        clear_mon();
        send_bits(b, bad_par, bad_stop, 11);
        repeat (12) @(negedge clk);
        ok = !bad_stop;
`ifdef PS2_PARITY_CHECK_EN
        ok = ok && !bad_par;
`endif
        exp = ok ? model_byte(b) : 0;
        chk({tag, "_op"}, last_op, exp);
        chk({tag, "_n"}, pulses, (exp != 0) ? 1 : 0);
        if (exp != 0) chk({tag, "_lat"}, pulse_cyc - stop_cyc, S + 2);
    endtask

    logic [7:0] pool [15];

    initial begin
        checks    = 0;
        errors    = 0;
        multi_hot = 0;
        stop_cyc  = 0;
        m_ext     = 1'b0;
        m_brk     = 1'b0;
        clear_mon();
        plain_map[8'h1D] = 5'b00001;
        plain_map[8'h1B] = 5'b00010;
        plain_map[8'h1C] = 5'b00100;
        plain_map[8'h23] = 5'b01000;
        plain_map[8'h29] = 5'b10000;
        plain_map[8'h5A] = 5'b10000;
        ext_map[8'h75]   = 5'b00001;
        ext_map[8'h72]   = 5'b00010;
        ext_map[8'h6B]   = 5'b00100;
        ext_map[8'h74]   = 5'b01000;
        ext_map[8'h5A]   = 5'b10000;
        pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h5A, 8'h75, 8'h72,
                 8'h6B, 8'h74, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h15};

        rst          = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_op", int'(bus.operation), 0);
        rst = 1'b0;
        clear_mon();
        repeat (1000) @(negedge clk);
        chk("idle_n", pulses, 0);

        frame("w", 8'h1D, 1'b0, 1'b0);
        frame("f0", 8'hF0, 1'b0, 1'b0);
        frame("w_brk", 8'h1D, 1'b0, 1'b0);
        frame("e0", 8'hE0, 1'b0, 1'b0);
        frame("e74", 8'h74, 1'b0, 1'b0);
        frame("e0b", 8'hE0, 1'b0, 1'b0);
        frame("f0b", 8'hF0, 1'b0, 1'b0);
        frame("e74b", 8'h74, 1'b0, 1'b0);
        frame("e0c", 8'hE0, 1'b0, 1'b0);
        frame("e1d", 8'h1D, 1'b0, 1'b0);
        frame("spc", 8'h29, 1'b0, 1'b0);
        frame("ent", 8'h5A, 1'b0, 1'b0);
        frame("q", 8'h15, 1'b0, 1'b0);
        frame("s", 8'h1B, 1'b0, 1'b0);

        clear_mon();
        send_bits(8'h55, 1'b0, 1'b0, 5);
        repeat (TO + 500) @(negedge clk);
        chk("tmo_n", pulses, 0);
        frame("a_tmo", 8'h1C, 1'b0, 1'b0);

        frame("d_bpar", 8'h23, 1'b1, 1'b0);
        frame("d_par", 8'h23, 1'b0, 1'b0);
        frame("bstop", 8'h1B, 1'b0, 1'b1);
        frame("s_stop", 8'h1B, 1'b0, 1'b0);

        clear_mon();
        @(negedge clk);
        bus.ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (H) @(negedge clk);
        frame("glitch", 8'h1D, 1'b0, 1'b0);

        frame("e0r", 8'hE0, 1'b0, 1'b0);
        clear_mon();
        send_bits(8'h75, 1'b0, 1'b0, 5);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_op", int'(bus.operation), 0);
        rst   = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (10) @(negedge clk);
        frame("post_rst", 8'h75, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [7:0] b;
            bit         bp;
            bit         bs;
            if ($urandom_range(9) < 7) b = pool[$urandom_range(14)];
            else b = 8'($urandom);
            bp = ($urandom_range(7) == 0);
            bs = ($urandom_range(11) == 0);
            frame("rnd", b, bp, bs);
        end

        chk("one_hot", multi_hot, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
